// File: rtl/hbm_read_dispatcher.sv
// Splits a byte-addressed read command into 4 KB-safe AXI INCR bursts, steers each to an
// HBM pseudo-channel by address, and throttles issue on per-channel outstanding-burst credits.
module hbm_read_dispatcher #(
    parameter int NUM_CH          = 4,
    parameter int CH_BYTES_LOG2   = 28,
    parameter int MAX_BEATS       = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_W            = 6,
    parameter int AXI_ID          = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_cmd_in_valid,
    output logic              io_cmd_in_ready,
    input  logic [63:0]       io_cmd_in_bits_addr,
    input  logic [31:0]       io_cmd_in_bits_len,
    output logic [NUM_CH-1:0] io_hbm_ar_valid,
    input  logic [NUM_CH-1:0] io_hbm_ar_ready,
    output logic [32:0]       io_hbm_ar_addr,
    output logic [3:0]        io_hbm_ar_len,
    output logic [ID_W-1:0]   io_hbm_ar_id,
    output logic [1:0]        io_hbm_ar_burst,
    output logic [2:0]        io_hbm_ar_size,
    output logic [3:0]        io_hbm_ar_cache,
    output logic              io_hbm_ar_lock,
    output logic [2:0]        io_hbm_ar_prot,
    output logic [3:0]        io_hbm_ar_qos,
    output logic [3:0]        io_hbm_ar_region,
    input  logic [NUM_CH-1:0] io_hbm_r_fire_last,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_err
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int BURST_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [63:0]        r_addr;
    logic [31:0]        r_beats_left;
    logic [BURST_W-1:0] r_burst;
    logic [CH_W-1:0]    r_ch;
    logic [32:0]        r_ar_addr;
    logic [3:0]         r_ar_len;
    logic               r_cmd_ready;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt [NUM_CH];

    logic               w_cmd_fire;
    logic [31:0]        w_beats_in;
    logic [7:0]         w_page_beats;
    logic [31:0]        w_lim;
    logic [BURST_W-1:0] w_burst_calc;
    logic [CH_W-1:0]    w_ch_calc;
    logic               w_can_issue;
    logic [NUM_CH-1:0]  w_ar_valid;
    logic [NUM_CH-1:0]  w_inc;
    logic               w_ar_fire;
    logic [31:0]        w_beats_rem;
    logic               w_all_idle;
    logic               w_err_evt;
    logic               w_done;

    assign w_cmd_fire   = io_cmd_in_valid && r_cmd_ready;
    assign w_beats_in   = {5'b0, io_cmd_in_bits_len[31:5]} + {31'b0, |io_cmd_in_bits_len[4:0]};
    // Beats left before the next 4 KB page; channel boundaries are page aligned too.
    assign w_page_beats = 8'd128 - {1'b0, r_addr[11:5]};
    assign w_ch_calc    = r_addr[CH_BYTES_LOG2 +: CH_W];
    assign w_can_issue  = r_cnt[r_ch] < CNT_W'(MAX_OUTSTANDING);
    assign w_ar_valid   = (r_state == S_ISSUE && w_can_issue) ? (NUM_CH'(1) << r_ch) : '0;
    assign w_inc        = w_ar_valid & io_hbm_ar_ready;
    assign w_ar_fire    = |w_inc;
    assign w_beats_rem  = r_beats_left - 32'(r_burst);

    always_comb begin
        w_lim = r_beats_left;
        if (w_lim > 32'(MAX_BEATS)) w_lim = 32'(MAX_BEATS);
        if (w_lim > {24'b0, w_page_beats}) w_lim = {24'b0, w_page_beats};
        w_burst_calc = BURST_W'(w_lim);
    end

    always_comb begin
        w_all_idle = 1'b1;
        w_err_evt  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cnt[i] != '0) w_all_idle = 1'b0;
            if (io_hbm_r_fire_last[i] && !w_inc[i] && r_cnt[i] == '0) w_err_evt = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:  if (w_cmd_fire) w_state_nxt = (w_beats_in == '0) ? S_DRAIN : S_CALC;
            S_CALC:  w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_ar_fire) w_state_nxt = (w_beats_rem != '0) ? S_CALC : S_DRAIN;
            S_DRAIN: begin
                if (w_all_idle) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_burst      <= '0;
            r_ch         <= '0;
            r_ar_addr    <= '0;
            r_ar_len     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            if (r_state == S_IDLE && w_cmd_fire) begin
                r_addr       <= io_cmd_in_bits_addr & ~64'h1F;
                r_beats_left <= w_beats_in;
            end
            if (r_state == S_CALC) begin
                r_burst   <= w_burst_calc;
                r_ch      <= w_ch_calc;
                r_ar_addr <= r_addr[32:0];
                r_ar_len  <= 4'(w_burst_calc - BURST_W'(1));
            end
            if (r_state == S_ISSUE && w_ar_fire) begin
                r_addr       <= r_addr + (64'(r_burst) << 5);
                r_beats_left <= w_beats_rem;
            end
        end
    end

    // Credit counters: a same-cycle issue and R-last on one channel cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_inc[i] && !io_hbm_r_fire_last[i])
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                else if (!w_inc[i] && io_hbm_r_fire_last[i] && r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
            if (w_err_evt) r_err <= 1'b1;
        end
    end

    assign io_cmd_in_ready  = r_cmd_ready;
    assign io_hbm_ar_valid  = w_ar_valid;
    assign io_hbm_ar_addr   = r_ar_addr;
    assign io_hbm_ar_len    = r_ar_len;
    assign io_hbm_ar_id     = ID_W'(AXI_ID);
    assign io_hbm_ar_burst  = 2'b01;
    assign io_hbm_ar_size   = 3'b101;
    assign io_hbm_ar_cache  = 4'b0;
    assign io_hbm_ar_lock   = 1'b0;
    assign io_hbm_ar_prot   = 3'b0;
    assign io_hbm_ar_qos    = 4'b0;
    assign io_hbm_ar_region = 4'b0;
    assign io_busy          = (r_state != S_IDLE);
    assign io_done          = w_done;
    assign io_err           = r_err;

endmodule
